// File: rtl/trigger_pkg.sv
// Shared types and bus-slicing helpers for the multi-channel trigger generator.
package trigger_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } trig_state_t;

  // LSB position of lane n inside a flattened bus of width-sized lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic logic is_active(input trig_state_t s);
    return (s == LOW) || (s == HIGH);
  endfunction

endpackage

// File: rtl/trigger_channel.sv
// One trigger lane: LOW/HIGH sequencer with shadowed periods and a saturating pulse count.
module trigger_channel
  import trigger_pkg::*;
#(
  parameter int W   = 32,
  parameter int W_s = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [W-1:0]   n_i,
  input  logic [W_s-1:0] li_i,
  input  logic [W_s-1:0] hi_i,
  output logic           trig_o,
  output logic           done_o,
  output logic           busy_o,
  output logic [W-1:0]   pulse_cnt_o
);

  trig_state_t    state_q, state_d;
  logic [W_s-1:0] phase_q, phase_d;
  logic [W_s-1:0] li_q, hi_q;
  logic [W-1:0]   pcnt_q, pcnt_d;
  logic           trig_q, trig_d;
  logic           done_q, done_d;

  logic [W_s-1:0] leff;
  logic [W_s-1:0] phase_inc;
  logic [W:0]     pcnt_inc;

  // A zero low time still costs one cycle so every pulse has a visible rising edge.
  assign leff      = (li_q == '0) ? W_s'(1) : li_q;
  assign phase_inc = phase_q + W_s'(1);
  assign pcnt_inc  = {1'b0, pcnt_q} + (W+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      li_q <= '0;
      hi_q <= '0;
    end else if (start_i) begin
      li_q <= li_i;
      hi_q <= hi_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      pcnt_q  <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pcnt_d  = pcnt_q;
    trig_d  = trig_q;
    done_d  = done_q;
    if (start_i) begin
      state_d = LOW;
      phase_d = '0;
      pcnt_d  = '0;
      trig_d  = 1'b0;
      done_d  = 1'b0;
    end else if (abort_i) begin
      state_d = IDLE;
      phase_d = '0;
      trig_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        LOW: begin
          if (hi_q == '0) begin
            state_d = DONE;
            phase_d = '0;
            done_d  = 1'b1;
          end else if (phase_inc >= leff) begin
            state_d = HIGH;
            phase_d = '0;
            trig_d  = 1'b1;
          end else begin
            phase_d = phase_inc;
          end
        end
        HIGH: begin
          if (phase_inc >= hi_q) begin
            phase_d = '0;
            trig_d  = 1'b0;
            pcnt_d  = (&pcnt_q) ? pcnt_q : pcnt_inc[W-1:0];
            // Burst end is judged on the unsaturated count so N = 2^W-1 still terminates.
            if ((n_i != '0) && (pcnt_inc == {1'b0, n_i})) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = LOW;
            end
          end else begin
            phase_d = phase_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign trig_o      = trig_q;
  assign done_o      = done_q;
  assign busy_o      = is_active(state_q);
  assign pulse_cnt_o = pcnt_q;

endmodule

// File: rtl/trigger_gen_multi.sv
// Multi-channel trigger generator: enable edge detection, shared burst count,
// global run counter and busy reduction around per-channel sequencers.
module trigger_gen_multi
  import trigger_pkg::*;
#(
  parameter int W   = 32,
  parameter int cnt = 32,
  parameter int i   = 4,
  parameter int W_s = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [W-1:0]     trigger_number_fixed,
  input  logic [i*W_s-1:0] Li,
  input  logic [i*W_s-1:0] Hi,
  output logic [i-1:0]     trigger_out,
  output logic [cnt-1:0]   counter,
  output logic [i*W-1:0]   pulse_count,
  output logic [i-1:0]     done,
  output logic             busy
);

  logic           enable_q;
  logic [W-1:0]   n_q;
  logic [cnt-1:0] counter_q, counter_d;
  logic [i-1:0]   ch_busy;
  logic           start;
  logic           abort;

  assign busy  = |ch_busy;
  assign start = enable & ~enable_q;
  assign abort = ~enable & busy;

  always_comb begin
    counter_d = counter_q;
    if (start) begin
      counter_d = '0;
    end else if (busy && !(&counter_q)) begin
      counter_d = counter_q + cnt'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q  <= 1'b0;
      n_q       <= '0;
      counter_q <= '0;
    end else begin
      enable_q  <= enable;
      counter_q <= counter_d;
      if (start) begin
        n_q <= trigger_number_fixed;
      end
    end
  end

  assign counter = counter_q;

  for (genvar g = 0; g < i; g++) begin : g_ch
    localparam int LS = lane_lsb(g, W_s);
    localparam int PS = lane_lsb(g, W);

    trigger_channel #(
      .W   (W),
      .W_s (W_s)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start),
      .abort_i     (abort),
      .n_i         (n_q),
      .li_i        (Li[LS +: W_s]),
      .hi_i        (Hi[LS +: W_s]),
      .trig_o      (trigger_out[g]),
      .done_o      (done[g]),
      .busy_o      (ch_busy[g]),
      .pulse_cnt_o (pulse_count[PS +: W])
    );
  end

endmodule
